// File: rtl/mc_ctrl_unit.sv
// Multi-cycle RV32 subset control unit.
// A single state register walks each instruction through
// IF -> ID -> EXE -> (MEM) -> WB. A wait counter bounds how long memory may
// stall, and a sticky fault register records an illegal opcode or a memory
// timeout. All datapath controls are decoded combinationally from the
// current state, the instruction register and mem_rdy.
module mc_ctrl_unit #(
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [31:0] inst,
    input  logic        mem_rdy,
    output logic [2:0]  state,
    output logic        memrd,
    output logic        memwr,
    output logic        iord,
    output logic        irwr,
    output logic        pcwr,
    output logic        regwr,
    output logic        m2reg,
    output logic [1:0]  alui,
    output logic        alusrcb,
    output logic [3:0]  aluc,
    output logic        retire,
    output logic [1:0]  fault
);

    // Wait counter must be able to hold WAIT_MAX itself.
    localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] WAIT_LIM = CW'(WAIT_MAX);

    // State encoding is architecturally visible on the state output.
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_IF   = 3'd1;
    localparam logic [2:0] S_ID   = 3'd2;
    localparam logic [2:0] S_EXE  = 3'd3;
    localparam logic [2:0] S_MEM  = 3'd4;
    localparam logic [2:0] S_WB   = 3'd5;
    localparam logic [2:0] S_HALT = 3'd6;

    // Instruction classes produced by the decoder.
    localparam logic [2:0] C_ILL = 3'd0;
    localparam logic [2:0] C_OPI = 3'd1;  // addi/xori/ori/andi
    localparam logic [2:0] C_SHF = 3'd2;  // slli/srli/srai
    localparam logic [2:0] C_R   = 3'd3;  // register-register ALU ops
    localparam logic [2:0] C_LW  = 3'd4;
    localparam logic [2:0] C_SW  = 3'd5;
    localparam logic [2:0] C_LUI = 3'd6;

    localparam logic [1:0] F_NONE    = 2'b00;
    localparam logic [1:0] F_ILLEGAL = 2'b01;
    localparam logic [1:0] F_TIMEOUT = 2'b10;

    // Classify an instruction word; anything outside the supported subset
    // is reported as illegal.
    function automatic logic [2:0] decode_class(input logic [31:0] ir);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [2:0] cls;
        opc = ir[6:0];
        f3  = ir[14:12];
        f7  = ir[31:25];
        cls = C_ILL;
        case (opc)
            7'b0010011: begin
                case (f3)
                    3'b000, 3'b100, 3'b110, 3'b111: cls = C_OPI;
                    3'b001: begin
                        if (f7 == 7'b0000000) cls = C_SHF;
                        else                  cls = C_ILL;
                    end
                    3'b101: begin
                        if ((f7 == 7'b0000000) || (f7 == 7'b0100000)) cls = C_SHF;
                        else                                          cls = C_ILL;
                    end
                    default: cls = C_ILL;
                endcase
            end
            7'b0110011: begin
                if (f7 == 7'b0000000) begin
                    cls = C_R;
                end else if ((f7 == 7'b0100000) &&
                             ((f3 == 3'b000) || (f3 == 3'b101))) begin
                    cls = C_R;
                end else begin
                    cls = C_ILL;
                end
            end
            7'b0000011: begin
                if (f3 == 3'b010) cls = C_LW;
                else              cls = C_ILL;
            end
            7'b0100011: begin
                if (f3 == 3'b010) cls = C_SW;
                else              cls = C_ILL;
            end
            7'b0110111: cls = C_LUI;
            default:    cls = C_ILL;
        endcase
        return cls;
    endfunction

    // Build {alui, alusrcb, aluc} for a decoded instruction.
    function automatic logic [6:0] alu_ctrl(input logic [2:0] cls, input logic [31:0] ir);
        logic [2:0] f3;
        logic [6:0] ctl;
        f3 = ir[14:12];
        case (cls)
            C_OPI: ctl = {2'b00, 1'b1, 1'b0, f3};
            C_SHF: begin
                // srai is the only immediate op that needs the arithmetic bit.
                if ((f3 == 3'b101) && ir[30]) ctl = {2'b01, 1'b1, 4'b1101};
                else                          ctl = {2'b01, 1'b1, 1'b0, f3};
            end
            C_R:   ctl = {2'b00, 1'b0, ir[30], f3};
            C_LW:  ctl = {2'b00, 1'b1, 4'b0000};
            C_SW:  ctl = {2'b10, 1'b1, 4'b0000};
            C_LUI: ctl = {2'b11, 1'b1, 4'b1111};
            default: ctl = 7'b000_0000;
        endcase
        return ctl;
    endfunction

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    fault_q, fault_d;
    logic [2:0]    cls_s;
    logic [6:0]    alu_s;
    logic          is_mem_op_s;
    logic          unused_inst_s;

    assign cls_s       = decode_class(inst);
    assign alu_s       = alu_ctrl(cls_s, inst);
    assign is_mem_op_s = (cls_s == C_LW) || (cls_s == C_SW);
    // Register-number fields are datapath concerns, not control.
    assign unused_inst_s = ^{inst[24:15], inst[11:7]};

    // Next-state, wait-counter and fault-capture logic.
    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        // Counter is zero on every transition, so it is clear on entry to IF/MEM.
        cnt_d   = {CW{1'b0}};
        case (state_q)
            S_IDLE: state_d = S_IF;
            S_IF: begin
                if (mem_rdy) begin
                    state_d = S_ID;
                end else if (cnt_q == WAIT_LIM) begin
                    state_d = S_HALT;
                    fault_d = F_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ID: begin
                if (cls_s == C_ILL) begin
                    state_d = S_HALT;
                    fault_d = F_ILLEGAL;
                end else begin
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                if (is_mem_op_s) state_d = S_MEM;
                else             state_d = S_WB;
            end
            S_MEM: begin
                if (mem_rdy) begin
                    if (cls_s == C_LW) state_d = S_WB;
                    else               state_d = S_IF;
                end else if (cnt_q == WAIT_LIM) begin
                    state_d = S_HALT;
                    fault_d = F_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WB:   state_d = S_IF;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // State, wait counter and sticky fault registers.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= S_IDLE;
            cnt_q   <= {CW{1'b0}};
            fault_q <= F_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    // Control strobes decoded from the current state, instruction and mem_rdy.
    always_comb begin
        memrd   = 1'b0;
        memwr   = 1'b0;
        iord    = 1'b0;
        irwr    = 1'b0;
        pcwr    = 1'b0;
        regwr   = 1'b0;
        m2reg   = 1'b0;
        retire  = 1'b0;
        alui    = 2'b00;
        alusrcb = 1'b0;
        aluc    = 4'b0000;
        case (state_q)
            S_IF: begin
                memrd = 1'b1;
                irwr  = mem_rdy;
                pcwr  = mem_rdy;
            end
            S_ID, S_EXE: begin
                {alui, alusrcb, aluc} = alu_s;
            end
            S_MEM: begin
                {alui, alusrcb, aluc} = alu_s;
                iord   = 1'b1;
                memrd  = (cls_s == C_LW);
                memwr  = (cls_s == C_SW);
                retire = (cls_s == C_SW) && mem_rdy;
            end
            S_WB: begin
                {alui, alusrcb, aluc} = alu_s;
                regwr  = 1'b1;
                m2reg  = (cls_s == C_LW);
                retire = 1'b1;
            end
            default: begin
                memrd = 1'b0;
            end
        endcase
    end

    assign state = state_q;
    assign fault = fault_q;

endmodule
